// File: rtl/wb_gpio_pkg.sv
// rtl/wb_gpio_pkg.sv - shared types and constants for the GPIO Wishbone arbiter
package wb_gpio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN0  = 2'd1,
      OWN1  = 2'd2,
      ABORT = 2'd3
   } wb_state_e;

   localparam int WB_ADDR_W      = 17;
   localparam int WB_DATA_W      = 32;
   localparam int WB_TIMEOUT_DEF = 255;
   localparam int WB_CNT_W       = 8;

endpackage

// File: rtl/wb_gpio_watchdog.sv
// rtl/wb_gpio_watchdog.sv - saturating stall counter that flags an unacknowledged client strobe
module wb_gpio_watchdog
   import wb_gpio_pkg::*;
#(
   parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [WB_CNT_W-1:0] LIMIT = WB_CNT_W'(TIMEOUT);

   logic [WB_CNT_W-1:0] cnt;

   // Holds at LIMIT so a stalled client can never wrap back to a quiet count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/wb_gpio_arbiter.sv
// rtl/wb_gpio_arbiter.sv - round-robin two-master Wishbone arbiter in front of the GPIO client port
module wb_gpio_arbiter
   import wb_gpio_pkg::*;
#(
   parameter int ADDR_W  = WB_ADDR_W,
   parameter int DATA_W  = WB_DATA_W,
   parameter int TIMEOUT = WB_TIMEOUT_DEF
) (
   input  logic                WB_CLK,
   input  logic                WB_RST_N,

   input  logic [ADDR_W-1:0]   M0_ADR,
   input  logic                M0_CYC,
   input  logic                M0_STB,
   input  logic                M0_WE,
   input  logic [DATA_W/8-1:0] M0_BYTE_STB,
   input  logic [DATA_W-1:0]   M0_WR_DAT,
   output logic [DATA_W-1:0]   M0_RD_DAT,
   output logic                M0_ACK,
   output logic                M0_ERR,

   input  logic [ADDR_W-1:0]   M1_ADR,
   input  logic                M1_CYC,
   input  logic                M1_STB,
   input  logic                M1_WE,
   input  logic [DATA_W/8-1:0] M1_BYTE_STB,
   input  logic [DATA_W-1:0]   M1_WR_DAT,
   output logic [DATA_W-1:0]   M1_RD_DAT,
   output logic                M1_ACK,
   output logic                M1_ERR,

   output logic [ADDR_W-1:0]   S_ADR,
   output logic                S_CYC,
   output logic                S_STB,
   output logic                S_WE,
   output logic [DATA_W/8-1:0] S_BYTE_STB,
   output logic [DATA_W-1:0]   S_WR_DAT,
   input  logic [DATA_W-1:0]   S_RD_DAT,
   input  logic                S_ACK,

   output logic [1:0]          GNT
);

   wb_state_e state_q, state_d;
   logic      last_q, last_d;
   logic      owned;
   logic      wd_clr;
   logic      wd_inc;
   logic      wd_expired;
   logic      timeout;

   always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
      if (!WB_RST_N) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

   assign owned   = (state_q == OWN0) || (state_q == OWN1);
   // A late ACK landing on the expiry cycle still wins over the error.
   assign timeout = owned && wd_expired && !S_ACK;

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (M0_CYC && !M1_CYC) begin
               state_d = OWN0;
            end else if (M1_CYC && !M0_CYC) begin
               state_d = OWN1;
            end else if (M0_CYC && M1_CYC) begin
               state_d = last_q ? OWN0 : OWN1;
            end
         end
         OWN0: begin
            if (timeout) begin
               state_d = ABORT;
               last_d  = 1'b0;
            end else if (!M0_CYC) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         OWN1: begin
            if (timeout) begin
               state_d = ABORT;
               last_d  = 1'b1;
            end else if (!M1_CYC) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      S_ADR      = '0;
      S_CYC      = 1'b0;
      S_STB      = 1'b0;
      S_WE       = 1'b0;
      S_BYTE_STB = '0;
      S_WR_DAT   = '0;
      M0_RD_DAT  = '0;
      M0_ACK     = 1'b0;
      M0_ERR     = 1'b0;
      M1_RD_DAT  = '0;
      M1_ACK     = 1'b0;
      M1_ERR     = 1'b0;
      case (state_q)
         OWN0: begin
            S_ADR      = M0_ADR;
            S_CYC      = M0_CYC;
            S_STB      = M0_STB;
            S_WE       = M0_WE;
            S_BYTE_STB = M0_BYTE_STB;
            S_WR_DAT   = M0_WR_DAT;
            M0_RD_DAT  = S_RD_DAT;
            M0_ACK     = S_ACK;
            M0_ERR     = timeout;
         end
         OWN1: begin
            S_ADR      = M1_ADR;
            S_CYC      = M1_CYC;
            S_STB      = M1_STB;
            S_WE       = M1_WE;
            S_BYTE_STB = M1_BYTE_STB;
            S_WR_DAT   = M1_WR_DAT;
            M1_RD_DAT  = S_RD_DAT;
            M1_ACK     = S_ACK;
            M1_ERR     = timeout;
         end
         default: begin
         end
      endcase
   end

   assign GNT = {state_q == OWN1, state_q == OWN0};

   // Idle and abort hold the counter at zero, so every new owner starts fresh.
   assign wd_clr = !owned || S_ACK;
   assign wd_inc = S_STB && !S_ACK;

   wb_gpio_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (WB_CLK),
      .rst_n   (WB_RST_N),
      .clr     (wd_clr),
      .inc     (wd_inc),
      .expired (wd_expired)
   );

endmodule

// File: doc/wb_gpio_arbiter.md
# wb_gpio_arbiter

Two-master Wishbone arbiter that shares the single Wishbone client port of the FPGA GPIO IP between the AHB-to-FPGA bridge (master 0) and an on-fabric requester such as a GPIO sequencer (master 1). It sits between the bridge's `WBs_*` outputs and the GPIO IP. It grants the bus round-robin per Wishbone cycle and holds the grant for the whole `CYC` envelope. A watchdog terminates any transfer the client fails to acknowledge.

## Interface
- `ADDR_W`, 17, address width (matches the `WBs_ADR` bus).
- `DATA_W`, 32, data width; byte strobes are `DATA_W/8` wide.
- `TIMEOUT`, 255, cycles from client strobe to forced error; legal range 1..255.
- `WB_CLK`  in  1  sole clock; all state is on its rising edge.
- `WB_RST_N`  in  1  reset, asynchronous assert, active-low; deassertion is synchronous to `WB_CLK` externally.
- `M0_ADR`/`M1_ADR`  in  ADDR_W  master address.
- `M0_CYC`/`M1_CYC`  in  1  cycle request; acts as the bus request.
- `M0_STB`/`M1_STB`  in  1  transfer strobe.
- `M0_WE`/`M1_WE`  in  1  write enable.
- `M0_BYTE_STB`/`M1_BYTE_STB`  in  DATA_W/8  byte enables.
- `M0_WR_DAT`/`M1_WR_DAT`  in  DATA_W  write data.
- `M0_RD_DAT`/`M1_RD_DAT`  out  DATA_W  read data; zero when not granted.
- `M0_ACK`/`M1_ACK`  out  1  acknowledge.
- `M0_ERR`/`M1_ERR`  out  1  one-cycle timeout error.
- `S_ADR`, `S_CYC`, `S_STB`, `S_WE`, `S_BYTE_STB`, `S_WR_DAT`  out  as above  to the client.
- `S_RD_DAT`  in  DATA_W; `S_ACK`  in  1  from the client.
- `GNT`  out  2  one-hot grant, `2'b00` when idle. Used for debug and status.

## Operation
- FSM states: `IDLE`, `OWN0`, `OWN1`, `ABORT`. Reset state is `IDLE`. The `last` pointer resets to 1, so master 0 wins the first tie.
- `IDLE`: if exactly one `Mx_CYC` is high, go to `OWNx`. If both are high, go to the master not equal to `last`. Otherwise stay.
- `OWNx`: forward master x's address, control and data to `S_*`.
  - Route `S_RD_DAT` and `S_ACK` to master x.
  - When `Mx_CYC` falls, go to `IDLE` and set `last` to x.
  - Block transfers (several `STB`s under one `CYC`) stay granted.
- Watchdog:
  - An 8-bit counter clears on entry to `OWNx` and on every `S_ACK`.
  - It increments while `S_STB && !S_ACK`.
  - When it reaches `TIMEOUT`, pulse `Mx_ERR` for 1 cycle and go to `ABORT`.
- `ABORT`: drive `S_CYC`/`S_STB` low for exactly 1 cycle, go to `IDLE`, and set `last` to x.
  - A master that still holds `CYC` is re-arbitrated from `IDLE`.
- When master x is not granted:
  - `Mx_ACK`, `Mx_ERR` and `Mx_RD_DAT` are 0.
  - Its requests are ignored; no buffering.
- When idle or in `ABORT`, all `S_*` outputs are 0.
- An `S_ACK` seen while idle or in `ABORT` is dropped.

## Timing
- Reset values: `GNT`=0, all `S_*` outputs 0, all `Mx_ACK`/`Mx_ERR`/`Mx_RD_DAT` 0, counter 0.
- Grant latency: `Mx_CYC` rises in cycle N (sampled at the edge ending N). `GNT` and `S_CYC` are high from cycle N+1.
- Data path: `S_*` outputs are a combinational mux on the registered state. `Mx_ACK` = `S_ACK` in the same cycle (zero added latency).
- Release: `Mx_CYC` low in cycle N frees the bus in cycle N+1. Another pending master is granted at N+2, so there is at least one idle cycle between owners.
- Simultaneous events:
  - An ACK in the same cycle the counter would hit `TIMEOUT` counts as success. No `ERR` is raised.
  - `Mx_CYC` dropping in the cycle of the timeout: the `ERR` pulse is still raised, and `ABORT` is still entered.
- Reset mid-transfer: all outputs go to 0 immediately (asynchronous). The in-flight client access is abandoned, and the client must tolerate `CYC` dropping.
- Counter width is 8 bits and never wraps; it saturates at `TIMEOUT`.

## Structure
- Shared package `wb_gpio_pkg`:
  - state enum `{IDLE, OWN0, OWN1, ABORT}`;
  - `WB_ADDR_W`=17, `WB_DATA_W`=32;
  - `WB_TIMEOUT_DEF`=255.
- One natural sub-module, `wb_gpio_watchdog`: the counter plus compare, with `clr`, `inc` and `expired` ports.
- The top-level integration places this block between the bridge and the GPIO IP's `WBs_*` port. `WB_RST_N` is the inverted `WB_RST_FPGA`.

## Test plan
- Solo access: M0 writes 0xA5A5_0001 to 0x0004, client ACKs after 2 cycles. Required: `S_CYC` high the cycle after `M0_CYC`, one `M0_ACK`, `M1_ACK` stays 0, `GNT`=01.
- Tie after reset: M0 and M1 raise `CYC` in the same cycle. Required: M0 granted first; M1 granted 2 cycles after M0 drops `CYC`; on a second tie, M1 is granted first.
- Block hold: M1 issues 4 back-to-back reads while M0 requests throughout. Required: `GNT` stays 10 for all 4 ACKs, and M0 receives no ACK until M1 releases.
- Timeout: `TIMEOUT`=8, client never ACKs M0. Required: `M0_ERR` pulses 8 cycles after `S_STB`, `S_CYC` is low for 1 cycle, then M1's pending request is granted.
- Edge ACK: with `TIMEOUT`=8, the client ACKs exactly on the 8th cycle. Required: `M0_ACK` high and `M0_ERR` low.
- Async reset: assert `WB_RST_N`=0 mid-read while owned by M1. Required: `GNT`, `S_CYC` and `M1_ACK` drop without waiting for a clock edge; after release the bus is idle and M0 wins the next tie.
